// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller:
// FSM states, access size codes and the IO region marker.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  localparam logic [1:0] IO_MASK_DEF = 2'b11;

  // Size code 11 is not a legal access; it is widened to a word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-bus bundle between the controller, its clients
// (ICache fetch port, LSB load/store port) and the 8-bit RAM/IO bus.
interface mem_ctrl_if;
  // Handshake: pc_flag / ls_flag are level requests held by the client until
  // the matching one-cycle done pulse (ins_flag / ls_done); the client must
  // drop the flag in the pulse cycle, during which the controller ignores it.
  logic [31:0] pc;
  logic        pc_flag;
  logic [31:0] ins;
  logic        ins_flag;
  logic [31:0] ls_addr;
  logic        ls_flag;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  pc, pc_flag, ls_addr, ls_flag, ls_wr, ls_size, ls_wdata,
           mem_din, io_buffer_full,
    output ins, ins_flag, ls_rdata, ls_done, mem_dout, mem_a, mem_wr
  );

  modport master (
    output pc, pc_flag, ls_addr, ls_flag, ls_wr, ls_size, ls_wdata,
           mem_din, io_buffer_full,
    input  ins, ins_flag, ls_rdata, ls_done, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates ICache fetches and LSB loads/stores onto a single-port 8-bit
// RAM bus, one byte per cycle, and returns assembled little-endian data.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_MASK = IO_MASK_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       clr,
  mem_ctrl_if.slave  bus,
  output state_e     dbg_state
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ins_q, ins_d;
  logic        ins_flag_q, ins_flag_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        rdy_q;
  logic [7:0]  din_hold_q;
  logic [7:0]  din_eff;
  logic [1:0]  cap_lane, nxt_lane;
  logic [2:0]  cnt_inc;
  logic        store_stall, accept_stall;

  // A freeze leaves mem_a parked, so the byte owed to the pending capture is
  // only on mem_din during the first frozen cycle; keep it for the resume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q      <= 1'b1;
      din_hold_q <= 8'd0;
    end else begin
      rdy_q <= rdy;
      if (rdy_q && !rdy) din_hold_q <= bus.mem_din;
    end
  end

  assign din_eff      = rdy_q ? bus.mem_din : din_hold_q;
  assign cnt_inc      = cnt_q + 3'd1;
  assign cap_lane     = 2'(cnt_q - 3'd1);
  assign nxt_lane     = 2'(cnt_inc);
  assign store_stall  = (addr_q[17:16] == IO_MASK) && bus.io_buffer_full;
  assign accept_stall = (bus.ls_addr[17:16] == IO_MASK) && bus.io_buffer_full;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    ins_d      = ins_q;
    ins_flag_d = 1'b0;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!clr && bus.ls_flag) begin
          state_d    = bus.ls_wr ? STORE : LOAD;
          addr_d     = bus.ls_addr;
          wdata_d    = bus.ls_wdata;
          nbytes_d   = byte_count(bus.ls_size);
          cnt_d      = 3'd0;
          buf_d      = 32'd0;
          mem_a_d    = bus.ls_addr;
          mem_dout_d = bus.ls_wdata[7:0];
          mem_wr_d   = bus.ls_wr && !accept_stall;
        end else if (!clr && bus.pc_flag) begin
          state_d  = IFETCH;
          addr_d   = bus.pc;
          nbytes_d = 3'd4;
          cnt_d    = 3'd0;
          buf_d    = 32'd0;
          mem_a_d  = bus.pc;
        end
      end
      IFETCH, LOAD: begin
        if (clr) begin
          state_d = IDLE;
        end else begin
          // cnt counts issued addresses; data for issue k lands one cycle later.
          if (cnt_q != 3'd0) buf_d = buf_q | ({24'd0, din_eff} << {cap_lane, 3'b000});
          if (cnt_q == nbytes_q) begin
            state_d = DONE;
            if (state_q == IFETCH) begin
              ins_d      = buf_d;
              ins_flag_d = 1'b1;
            end else begin
              rdata_d = buf_d;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < nbytes_q) mem_a_d = addr_q + 32'(cnt_inc);
          end
        end
      end
      STORE: begin
        if (mem_wr_q) begin
          if (cnt_q == nbytes_q - 3'd1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d      = cnt_inc;
            mem_a_d    = addr_q + 32'(cnt_inc);
            mem_dout_d = 8'(wdata_q >> {nxt_lane, 3'b000});
            mem_wr_d   = !store_stall;
          end
        end else begin
          mem_wr_d = !store_stall;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      nbytes_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      buf_q      <= 32'd0;
      ins_q      <= 32'd0;
      ins_flag_q <= 1'b0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      ins_q      <= ins_d;
      ins_flag_q <= ins_flag_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign bus.ins      = ins_q;
  assign bus.ins_flag = ins_flag_q;
  assign bus.ls_rdata = rdata_q;
  assign bus.ls_done  = done_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = mem_wr_q & rdy;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: RAM model, scoreboard queues for fetch,
// load/store completions and RAM writes, plus cycle-accurate latency checks.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   rdy = 1'b1;
  logic   clr = 1'b0;
  state_e dbg_state;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // RAM model: read data valid the cycle after the address is presented
  logic [7:0]  ram [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_a  = 12'd0;
  logic [7:0]  pre_d  = 8'd0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[11:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_ins_q [$];
  logic [32:0] exp_ls_q  [$];
  logic [39:0] exp_wr_q  [$];

  logic [31:0] a_trace  [0:31];
  logic        wr_trace [0:31];
  logic [2:0]  st_trace [0:31];

  int full_cycles = 0;
  int clr_at      = -1;
  int rdy_lo_at   = -1;
  int rdy_lo_len  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [31:0] a);
    bus.pc      = a;
    bus.pc_flag = 1'b1;
  endtask

  task automatic start_ls(input logic wr, input logic [1:0] size, input logic [31:0] a,
                          input logic [31:0] wd);
    bus.ls_flag  = 1'b1;
    bus.ls_wr    = wr;
    bus.ls_size  = size;
    bus.ls_addr  = a;
    bus.ls_wdata = wd;
  endtask

  // Called in T0; returns k when the pulse is seen in Tk, 0 if none in budget.
  task automatic wait_pulse(input int which, input int max, output int lat);
    lat = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      a_trace[i]  = bus.mem_a;
      wr_trace[i] = bus.mem_wr;
      st_trace[i] = dbg_state;
      if ((which == 0 && bus.ins_flag) || (which == 1 && bus.ls_done)) begin
        lat = i;
        break;
      end
      bus.io_buffer_full = (i < full_cycles);
      clr = (i == clr_at);
      if (i == clr_at) bus.pc_flag = 1'b0;
      rdy = !(i >= rdy_lo_at && i < rdy_lo_at + rdy_lo_len);
    end
    clr = 1'b0;
    rdy = 1'b1;
    bus.io_buffer_full = 1'b0;
    full_cycles = 0;
    clr_at      = -1;
    rdy_lo_at   = -1;
    rdy_lo_len  = 0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    tick();
    pre_we = 1'b0;
  endtask

  // Scoreboard: every completion pulse and RAM write pops an expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ins_flag) begin
        check("ins_expected", exp_ins_q.size() != 0, 1);
        if (exp_ins_q.size() != 0) check("ins_data", bus.ins, exp_ins_q.pop_front());
      end
      if (bus.ls_done) begin
        check("ls_expected", exp_ls_q.size() != 0, 1);
        if (exp_ls_q.size() != 0) begin
          logic [32:0] e;
          e = exp_ls_q.pop_front();
          if (e[32]) check("ls_rdata", bus.ls_rdata, e[31:0]);
        end
      end
      if (bus.mem_wr) begin
        check("wr_expected", exp_wr_q.size() != 0, 1);
        if (exp_wr_q.size() != 0) check("wr_addr_data", {bus.mem_a, bus.mem_dout}, exp_wr_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bus.pc = 32'd0; bus.pc_flag = 1'b0;
    bus.ls_addr = 32'd0; bus.ls_flag = 1'b0; bus.ls_wr = 1'b0;
    bus.ls_size = BYTE; bus.ls_wdata = 32'd0; bus.io_buffer_full = 1'b0;

    preload(12'h100, 8'h13); preload(12'h101, 8'h05);
    preload(12'h102, 8'hA0); preload(12'h103, 8'h00);
    preload(12'h200, 8'h11); preload(12'h201, 8'h22);
    preload(12'h202, 8'h33); preload(12'h203, 8'h44);

    check("rst_ins", bus.ins, 32'd0);
    check("rst_rdata", bus.ls_rdata, 32'd0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_dout", bus.mem_dout, 8'd0);
    check("rst_pulses", {bus.ins_flag, bus.ls_done, bus.mem_wr}, 3'b000);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    tick();

    // Word fetch
    start_fetch(32'h100);
    exp_ins_q.push_back(32'h00A00513);
    wait_pulse(0, 12, lat);
    bus.pc_flag = 1'b0;
    check("fetch_latency", lat, 6);
    for (int k = 0; k < 4; k++) check("fetch_mem_a", a_trace[k + 1], 32'h100 + k);
    tick();

    // Load wins over simultaneous fetch; fetch follows after DONE
    start_fetch(32'h100);
    start_ls(1'b0, WORD, 32'h200, 32'd0);
    exp_ls_q.push_back({1'b1, 32'h44332211});
    exp_ins_q.push_back(32'h00A00513);
    wait_pulse(1, 12, lat);
    bus.ls_flag = 1'b0;
    check("arb_load_latency", lat, 6);
    wait_pulse(0, 12, lat);
    bus.pc_flag = 1'b0;
    check("arb_fetch_after_done", lat, 7);
    tick();

    // Store half, then byte readback
    start_ls(1'b1, HALF, 32'h301, 32'h0000BEEF);
    exp_wr_q.push_back({32'h301, 8'hEF});
    exp_wr_q.push_back({32'h302, 8'hBE});
    exp_ls_q.push_back({1'b0, 32'd0});
    wait_pulse(1, 10, lat);
    bus.ls_flag = 1'b0;
    check("store_half_latency", lat, 3);
    check("store_half_wr_cycles", {wr_trace[1], wr_trace[2]}, 2'b11);
    tick();
    check("store_half_drain", exp_wr_q.size(), 0);
    start_ls(1'b0, BYTE, 32'h302, 32'd0);
    exp_ls_q.push_back({1'b1, 32'h000000BE});
    wait_pulse(1, 10, lat);
    bus.ls_flag = 1'b0;
    check("load_byte_latency", lat, 3);
    tick();

    // IO store stalled by a full UART buffer for 3 cycles
    bus.io_buffer_full = 1'b1;
    full_cycles = 3;
    start_ls(1'b1, BYTE, 32'h30000, 32'h0000005A);
    exp_wr_q.push_back({32'h30000, 8'h5A});
    exp_ls_q.push_back({1'b0, 32'd0});
    wait_pulse(1, 12, lat);
    bus.ls_flag = 1'b0;
    check("io_store_latency", lat, 5);
    check("io_store_stalled_wr", {wr_trace[1], wr_trace[2], wr_trace[3]}, 3'b000);
    check("io_store_wr", wr_trace[4], 1'b1);
    tick();

    // Flush aborts a fetch in T3
    clr_at = 3;
    start_fetch(32'h100);
    wait_pulse(0, 10, lat);
    check("clr_fetch_no_pulse", lat, 0);
    check("clr_fetch_idle", st_trace[4], IDLE);
    check("clr_fetch_ins_held", bus.ins, 32'h00A00513);

    // Flush does not abort a committed word store
    clr_at = 2;
    start_ls(1'b1, WORD, 32'h400, 32'hCAFEF00D);
    exp_wr_q.push_back({32'h400, 8'h0D});
    exp_wr_q.push_back({32'h401, 8'hF0});
    exp_wr_q.push_back({32'h402, 8'hFE});
    exp_wr_q.push_back({32'h403, 8'hCA});
    exp_ls_q.push_back({1'b0, 32'd0});
    wait_pulse(1, 12, lat);
    bus.ls_flag = 1'b0;
    check("clr_store_latency", lat, 5);
    tick();
    check("clr_store_drain", exp_wr_q.size(), 0);

    // Asynchronous reset in the middle of a load
    start_ls(1'b0, WORD, 32'h200, 32'd0);
    tick(); tick(); tick();
    check("midload_mem_a", bus.mem_a, 32'h202);
    rst = 1'b1;
    #1;
    check("arst_ins", bus.ins, 32'd0);
    check("arst_rdata", bus.ls_rdata, 32'd0);
    check("arst_mem_a", bus.mem_a, 32'd0);
    check("arst_dout", bus.mem_dout, 8'd0);
    check("arst_pulses", {bus.ins_flag, bus.ls_done, bus.mem_wr}, 3'b000);
    check("arst_state", dbg_state, IDLE);
    bus.ls_flag = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // rdy low for two cycles mid-fetch
    rdy_lo_at  = 2;
    rdy_lo_len = 2;
    start_fetch(32'h200);
    exp_ins_q.push_back(32'h44332211);
    wait_pulse(0, 14, lat);
    bus.pc_flag = 1'b0;
    check("rdy_stall_latency", lat, 8);
    tick();

    check("final_ins_drain", exp_ins_q.size(), 0);
    check("final_ls_drain", exp_ls_q.size(), 0);
    check("final_wr_drain", exp_wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
